// File: rtl/lsa_pkg.sv
// Shared definitions for the lsa memory arbiter: port ids, bus widths and
// the request record carried from a master to the memory side.
package lsa_pkg;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int LSA_ADDR_W = 16;
    localparam int LSA_DATA_W = 16;

    typedef struct packed {
        logic                  we;
        logic                  fetch;
        logic [LSA_ADDR_W-1:0] add;
        logic [LSA_DATA_W-1:0] wdata;
    } lsa_req_t;

endpackage

// File: rtl/lsa_arb_pick.sv
// Combinational winner selection between port A and port B, honouring the
// B burst lock and either round-robin or fixed-priority tie breaking.
module lsa_arb_pick
    import lsa_pkg::*;
#(
    parameter int RR       = 1,
    parameter int LOCK_MAX = 8
) (
    input  logic       a_req,
    input  logic       b_req,
    input  logic       b_lock,
    input  logic       last_gnt,
    input  logic       lock_act,
    input  logic [7:0] lock_cnt,
    output logic       grant_a,
    output logic       grant_b
);

    localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

    logic locked;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        // A lock only survives a cycle in which B still asks for it.
        locked  = lock_act && b_lock;
        if (a_req && b_req) begin
            if (locked) begin
                if (lock_cnt >= LOCK_LIM) grant_a = 1'b1;
                else                      grant_b = 1'b1;
            end else if ((RR != 0) && (last_gnt == PORT_A)) begin
                grant_b = 1'b1;
            end else begin
                grant_a = 1'b1;
            end
        end else begin
            grant_a = a_req;
            grant_b = b_req;
        end
    end

endmodule

// File: rtl/lsa_mem_arbiter.sv
// Shares the single lsa_mem port between lsa_core (A) and a second master (B):
// registered memory-side issue, tagged read return, bounded B burst lock.
module lsa_mem_arbiter
    import lsa_pkg::*;
#(
    parameter int RR       = 1,
    parameter int LOCK_MAX = 8
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic                  a_fetch,
    input  logic [LSA_ADDR_W-1:0] a_add,
    input  logic [LSA_DATA_W-1:0] a_wdata,
    output logic                  a_ack,
    output logic [LSA_DATA_W-1:0] a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic                  b_fetch,
    input  logic [LSA_ADDR_W-1:0] b_add,
    input  logic [LSA_DATA_W-1:0] b_wdata,
    output logic                  b_ack,
    output logic [LSA_DATA_W-1:0] b_rdata,
    output logic                  b_rvalid,
    input  logic                  b_lock,
    output logic                  mem_fetch,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [LSA_ADDR_W-1:0] mem_add,
    output logic [LSA_DATA_W-1:0] mem_in,
    input  logic [LSA_DATA_W-1:0] mem_out
);

    localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

    lsa_req_t              req_a, req_b, win;
    logic                  grant_a, grant_b, accept;
    logic                  mem_fetch_q, mem_fetch_d, mem_we_q, mem_we_d, mem_oe_q, mem_oe_d;
    logic [LSA_ADDR_W-1:0] mem_add_q, mem_add_d;
    logic [LSA_DATA_W-1:0] mem_in_q, mem_in_d;
    logic                  rd_vld_p1_q, rd_vld_p1_d, rd_port_p1_q, rd_port_p1_d;
    logic                  rd_vld_p2_q, rd_port_p2_q;
    logic                  last_gnt_q, last_gnt_d;
    logic                  lock_act_q, lock_act_d;
    logic [7:0]            lock_cnt_q, lock_cnt_d;

    lsa_arb_pick #(.RR(RR), .LOCK_MAX(LOCK_MAX)) u_pick (
        .a_req    (a_req),
        .b_req    (b_req),
        .b_lock   (b_lock),
        .last_gnt (last_gnt_q),
        .lock_act (lock_act_q),
        .lock_cnt (lock_cnt_q),
        .grant_a  (grant_a),
        .grant_b  (grant_b)
    );

    always_comb begin
        req_a        = '{we: a_we, fetch: a_fetch, add: a_add, wdata: a_wdata};
        req_b        = '{we: b_we, fetch: b_fetch, add: b_add, wdata: b_wdata};
        win          = grant_b ? req_b : req_a;
        accept       = grant_a | grant_b;

        mem_we_d     = accept & win.we;
        mem_oe_d     = accept & ~win.we;
        mem_fetch_d  = accept & win.fetch;
        mem_add_d    = accept ? win.add : mem_add_q;
        mem_in_d     = (accept && win.we) ? win.wdata : mem_in_q;

        rd_vld_p1_d  = accept & ~win.we;
        rd_port_p1_d = grant_b ? PORT_B : PORT_A;
        last_gnt_d   = accept ? (grant_b ? PORT_B : PORT_A) : last_gnt_q;

        lock_act_d   = lock_act_q;
        lock_cnt_d   = lock_cnt_q;
        if (!b_req || !b_lock) begin
            lock_act_d = 1'b0;
            lock_cnt_d = 8'd0;
        end else if (grant_b) begin
            // Saturate so a late A request is served at its first contention.
            lock_act_d = 1'b1;
            lock_cnt_d = (lock_cnt_q == LOCK_LIM) ? lock_cnt_q : lock_cnt_q + 8'd1;
        end else if (grant_a) begin
            lock_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            mem_fetch_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_oe_q     <= 1'b0;
            mem_add_q    <= '0;
            mem_in_q     <= '0;
            rd_vld_p1_q  <= 1'b0;
            rd_port_p1_q <= PORT_A;
            rd_vld_p2_q  <= 1'b0;
            rd_port_p2_q <= PORT_A;
            last_gnt_q   <= PORT_B;
            lock_act_q   <= 1'b0;
            lock_cnt_q   <= 8'd0;
        end else begin
            // Issue stage: memory side sees the accepted request one cycle later.
            mem_fetch_q  <= mem_fetch_d;
            mem_we_q     <= mem_we_d;
            mem_oe_q     <= mem_oe_d;
            mem_add_q    <= mem_add_d;
            mem_in_q     <= mem_in_d;
            rd_vld_p1_q  <= rd_vld_p1_d;
            rd_port_p1_q <= rd_port_p1_d;
            // Return stage: tag lines up with mem_out.
            rd_vld_p2_q  <= rd_vld_p1_q;
            rd_port_p2_q <= rd_port_p1_q;
            last_gnt_q   <= last_gnt_d;
            lock_act_q   <= lock_act_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

    assign a_ack     = grant_a;
    assign b_ack     = grant_b;
    assign mem_fetch = mem_fetch_q;
    assign mem_we    = mem_we_q;
    assign mem_oe    = mem_oe_q;
    assign mem_add   = mem_add_q;
    assign mem_in    = mem_in_q;
    assign a_rdata   = mem_out;
    assign b_rdata   = mem_out;
    assign a_rvalid  = rd_vld_p2_q && (rd_port_p2_q == PORT_A);
    assign b_rvalid  = rd_vld_p2_q && (rd_port_p2_q == PORT_B);

endmodule

// File: tb/tb_lsa_mem_arbiter.sv
// Directed bench for lsa_mem_arbiter (RR=1, LOCK_MAX=4) with a small
// synchronous memory model behind the arbiter.
module tb_lsa_mem_arbiter;

    logic        clock_in = 1'b0;
    logic        reset_in;
    logic        a_req, a_we, a_fetch, b_req, b_we, b_fetch, b_lock;
    logic [15:0] a_add, a_wdata, b_add, b_wdata;
    logic        a_ack, a_rvalid, b_ack, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic        mem_fetch, mem_we, mem_oe;
    logic [15:0] mem_add, mem_in;
    logic [15:0] mem_out;
    logic [15:0] mem [256];

    int checks   = 0;
    int failures = 0;

    lsa_mem_arbiter #(.RR(1), .LOCK_MAX(4)) dut (
        .clock_in (clock_in), .reset_in (reset_in),
        .a_req    (a_req),    .a_we     (a_we),    .a_fetch  (a_fetch),
        .a_add    (a_add),    .a_wdata  (a_wdata), .a_ack    (a_ack),
        .a_rdata  (a_rdata),  .a_rvalid (a_rvalid),
        .b_req    (b_req),    .b_we     (b_we),    .b_fetch  (b_fetch),
        .b_add    (b_add),    .b_wdata  (b_wdata), .b_ack    (b_ack),
        .b_rdata  (b_rdata),  .b_rvalid (b_rvalid), .b_lock  (b_lock),
        .mem_fetch(mem_fetch), .mem_we  (mem_we),  .mem_oe   (mem_oe),
        .mem_add  (mem_add),  .mem_in   (mem_in),  .mem_out  (mem_out)
    );

    always #5 clock_in = ~clock_in;

    // Memory model: read data appears the cycle after mem_oe.
    always @(posedge clock_in) begin
        if (reset_in) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 | 16'(i);
            mem[8'h40] <= 16'hBEEF;
            mem_out    <= 16'h0000;
        end else begin
            if (mem_we) mem[mem_add[7:0]] <= mem_in;
            if (mem_oe) mem_out <= mem[mem_add[7:0]];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    task automatic idle();
        a_req = 1'b0; a_we = 1'b0; a_fetch = 1'b0; a_add = 16'h0; a_wdata = 16'h0;
        b_req = 1'b0; b_we = 1'b0; b_fetch = 1'b0; b_add = 16'h0; b_wdata = 16'h0;
        b_lock = 1'b0;
    endtask

    typedef struct {
        logic a_req, a_we, a_fetch; logic [15:0] a_add, a_wdata;
        logic b_req, b_we;          logic [15:0] b_add, b_wdata; logic b_lock;
        logic e_aack, e_back, e_oe, e_we, e_fetch; logic [15:0] e_add, e_in;
        logic e_arv, e_brv;         logic [15:0] e_rdata;
    } vec_t;

    vec_t tbl [20];

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    initial begin
        tbl[0]  = '{I,O,I,16'h0040,16'h0, O,O,16'h0000,16'h0,O, I,O, O,O,O,16'h0000,16'h0000, O,O,16'h0000};
        tbl[1]  = '{O,O,O,16'h0000,16'h0, O,O,16'h0000,16'h0,O, O,O, I,O,I,16'h0040,16'h0000, O,O,16'h0000};
        tbl[2]  = '{O,O,O,16'h0000,16'h0, O,O,16'h0000,16'h0,O, O,O, O,O,O,16'h0040,16'h0000, I,O,16'hBEEF};
        tbl[3]  = '{O,O,O,16'h0000,16'h0, O,O,16'h0000,16'h0,O, O,O, O,O,O,16'h0040,16'h0000, O,O,16'h0000};
        tbl[4]  = '{I,O,O,16'h0010,16'h0, I,O,16'h0020,16'h0,O, O,I, O,O,O,16'h0040,16'h0000, O,O,16'h0000};
        tbl[5]  = '{I,O,O,16'h0010,16'h0, I,O,16'h0021,16'h0,O, I,O, I,O,O,16'h0020,16'h0000, O,O,16'h0000};
        tbl[6]  = '{I,O,O,16'h0011,16'h0, I,O,16'h0021,16'h0,O, O,I, I,O,O,16'h0010,16'h0000, O,I,16'hA020};
        tbl[7]  = '{I,O,O,16'h0011,16'h0, I,O,16'h0022,16'h0,O, I,O, I,O,O,16'h0021,16'h0000, I,O,16'hA010};
        tbl[8]  = '{I,O,O,16'h0012,16'h0, I,O,16'h0022,16'h0,O, O,I, I,O,O,16'h0011,16'h0000, O,I,16'hA021};
        tbl[9]  = '{I,O,O,16'h0012,16'h0, I,O,16'h0023,16'h0,O, I,O, I,O,O,16'h0022,16'h0000, I,O,16'hA011};
        tbl[10] = '{O,O,O,16'h0000,16'h0, O,O,16'h0000,16'h0,O, O,O, I,O,O,16'h0012,16'h0000, O,I,16'hA022};
        tbl[11] = '{O,O,O,16'h0000,16'h0, O,O,16'h0000,16'h0,O, O,O, O,O,O,16'h0012,16'h0000, I,O,16'hA012};
        tbl[12] = '{O,O,O,16'h0000,16'h0, O,O,16'h0000,16'h0,O, O,O, O,O,O,16'h0012,16'h0000, O,O,16'h0000};
        tbl[13] = '{O,O,O,16'h0000,16'h0, I,I,16'h0100,16'h1234,O, O,I, O,O,O,16'h0012,16'h0000, O,O,16'h0000};
        tbl[14] = '{O,O,O,16'h0000,16'h0, I,O,16'h0100,16'h0,O, O,I, O,I,O,16'h0100,16'h1234, O,O,16'h0000};
        tbl[15] = '{O,O,O,16'h0000,16'h0, O,O,16'h0000,16'h0,O, O,O, I,O,O,16'h0100,16'h1234, O,O,16'h0000};
        tbl[16] = '{O,O,O,16'h0000,16'h0, O,O,16'h0000,16'h0,O, O,O, O,O,O,16'h0100,16'h1234, O,I,16'h1234};
        tbl[17] = '{I,I,O,16'h0055,16'h5555, O,O,16'h0000,16'h0,O, I,O, O,O,O,16'h0100,16'h1234, O,O,16'h0000};
        tbl[18] = '{O,O,O,16'h0000,16'h0, O,O,16'h0000,16'h0,O, O,O, O,I,O,16'h0055,16'h5555, O,O,16'h0000};
        tbl[19] = '{O,O,O,16'h0000,16'h0, O,O,16'h0000,16'h0,O, O,O, O,O,O,16'h0055,16'h5555, O,O,16'h0000};

        idle();
        reset_in = 1'b1;
        repeat (2) @(posedge clock_in);
        #1 reset_in = 1'b0;

        for (int c = 0; c < 10; c++) begin
            @(negedge clock_in);
            chk($sformatf("idle%0d_mem_oe", c), 32'(mem_oe), 32'd0);
            chk($sformatf("idle%0d_mem_we", c), 32'(mem_we), 32'd0);
            chk($sformatf("idle%0d_mem_fetch", c), 32'(mem_fetch), 32'd0);
            chk($sformatf("idle%0d_mem_add", c), 32'(mem_add), 32'h0);
            chk($sformatf("idle%0d_rvalid", c), {30'd0, a_rvalid, b_rvalid}, 32'd0);
        end
        @(posedge clock_in); #1;

        for (int r = 0; r < 20; r++) begin
            a_req = tbl[r].a_req; a_we = tbl[r].a_we; a_fetch = tbl[r].a_fetch;
            a_add = tbl[r].a_add; a_wdata = tbl[r].a_wdata;
            b_req = tbl[r].b_req; b_we = tbl[r].b_we; b_add = tbl[r].b_add;
            b_wdata = tbl[r].b_wdata; b_lock = tbl[r].b_lock;
            @(negedge clock_in);
            chk($sformatf("row%0d_a_ack", r), 32'(a_ack), 32'(tbl[r].e_aack));
            chk($sformatf("row%0d_b_ack", r), 32'(b_ack), 32'(tbl[r].e_back));
            chk($sformatf("row%0d_mem_oe", r), 32'(mem_oe), 32'(tbl[r].e_oe));
            chk($sformatf("row%0d_mem_we", r), 32'(mem_we), 32'(tbl[r].e_we));
            chk($sformatf("row%0d_mem_fetch", r), 32'(mem_fetch), 32'(tbl[r].e_fetch));
            chk($sformatf("row%0d_mem_add", r), 32'(mem_add), 32'(tbl[r].e_add));
            chk($sformatf("row%0d_mem_in", r), 32'(mem_in), 32'(tbl[r].e_in));
            chk($sformatf("row%0d_a_rvalid", r), 32'(a_rvalid), 32'(tbl[r].e_arv));
            chk($sformatf("row%0d_b_rvalid", r), 32'(b_rvalid), 32'(tbl[r].e_brv));
            if (tbl[r].e_arv) chk($sformatf("row%0d_a_rdata", r), 32'(a_rdata), 32'(tbl[r].e_rdata));
            if (tbl[r].e_brv) chk($sformatf("row%0d_b_rdata", r), 32'(b_rdata), 32'(tbl[r].e_rdata));
            @(posedge clock_in); #1;
        end

        // Lock burst: B alone first, then A contends every cycle.
        begin
            logic [5:0] exp_b, exp_a;
            exp_b = 6'b101111;
            exp_a = 6'b010000;
            for (int c = 0; c < 6; c++) begin
                b_req = 1'b1; b_lock = 1'b1; b_we = 1'b0; b_add = 16'h0030 + 16'(c);
                a_req = (c >= 1); a_we = 1'b0; a_add = 16'h0031;
                @(negedge clock_in);
                chk($sformatf("lock%0d_b_ack", c), 32'(b_ack), 32'(exp_b[c]));
                chk($sformatf("lock%0d_a_ack", c), 32'(a_ack), 32'(exp_a[c]));
                @(posedge clock_in); #1;
            end
            idle();
            repeat (3) @(posedge clock_in);
            #1;
        end

        // Reset during an A read in flight.
        a_req = 1'b1; a_we = 1'b0; a_add = 16'h0040;
        @(negedge clock_in);
        chk("rst_a_ack", 32'(a_ack), 32'd1);
        @(posedge clock_in); #1;
        idle();
        reset_in = 1'b1;
        #1;
        chk("rst_mem_oe_drop", 32'(mem_oe), 32'd0);
        @(negedge clock_in);
        reset_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock_in);
            chk($sformatf("rst%0d_a_rvalid", c), 32'(a_rvalid), 32'd0);
            chk($sformatf("rst%0d_b_rvalid", c), 32'(b_rvalid), 32'd0);
        end
        @(posedge clock_in); #1;
        a_req = 1'b1; a_we = 1'b0; a_add = 16'h0041;
        @(negedge clock_in);
        chk("post_rst_a_ack", 32'(a_ack), 32'd1);
        @(posedge clock_in); #1;
        idle();
        @(negedge clock_in);
        chk("post_rst_mem_oe", 32'(mem_oe), 32'd1);
        chk("post_rst_mem_add", 32'(mem_add), 32'h0041);
        @(posedge clock_in); #1;
        @(negedge clock_in);
        chk("post_rst_a_rvalid", 32'(a_rvalid), 32'd1);
        chk("post_rst_a_rdata", 32'(a_rdata), 32'hA041);
        chk("post_rst_b_rvalid", 32'(b_rvalid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
